uart_bps_gen: RTL and testbench
===============================

// Module: uart_bps_gen
// PURPOSE
//   Runtime-selectable UART bit-timing generator; successor to the fixed-rate speed_setting block.
//   Produces a mid-bit strobe (RX sampling) and a bit-end strobe (TX shifting) at eight selectable baud rates.
//   Counts bit periods itself and stops automatically after one frame.
//   One instance per UART direction; sits between the rx/tx shifters and the system clock.
// PARAMETERS
//   CLK_FREQ    25_000_000  system clock frequency in Hz
//   FRAME_BITS  10          bit periods per frame (start + 8 data + stop); legal range 1..15
//   CNT_W       16          bit-period counter width; must hold CLK_FREQ/1200
// PORTS
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous reset, active-low
//   bps_start   in   1      frame request; the rising edge is detected internally
//   bps_abort   in   1      synchronous abort; returns to IDLE
//   bps_sel     in   3      baud select: 0=1200 1=2400 2=4800 3=9600 4=19200 5=38400 6=57600 7=115200
//   bps_hf      out  1      1-cycle strobe at mid-bit
//   bps_full    out  1      1-cycle strobe at end of bit
//   bit_cnt     out  4      index of the current bit, 0..FRAME_BITS-1
//   busy        out  1      high while a frame is being timed
//   frame_done  out  1      1-cycle strobe coinciding with the last bps_full
// BEHAVIOUR
//   Reset
//     - rst low clears all state asynchronously: state=IDLE, cnt=0, bit_cnt=0.
//     - All outputs are 0. The edge-detect register is also 0.
//     - A reset mid-frame ends the frame with no further strobes.
//   Divisor
//     - DIV(sel)  = CLK_FREQ/baud - 1 (integer truncation); HALF = DIV>>1.
//     - Both are constants per sel, computed at elaboration.
//     - Default values: sel7 DIV=216 HALF=108; sel3 DIV=2603 HALF=1301; sel0 DIV=20832.
//     - bps_sel is latched into sel_r on the start edge. Changes to bps_sel while busy are ignored.
//   State machine (IDLE, RUN)
//     - IDLE -> RUN: on the clock edge where bps_start=1 and its registered previous value was 0
//       (called edge E0). At E0: cnt<=0, bit_cnt<=0, busy<=1.
//     - RUN: cnt increments every cycle.
//       - When cnt==HALF: bps_hf<=1 for one cycle.
//       - When cnt==DIV: bps_full<=1, cnt<=0, and bit_cnt increments.
//       - When cnt==DIV and bit_cnt==FRAME_BITS-1: bps_full<=1, frame_done<=1, busy<=0, bit_cnt<=0, state<=IDLE.
//     - Timing from E0: bps_hf is high during cycle HALF+1; bps_full is high during cycle DIV+1.
//       The bit period is DIV+1 cycles.
//     - Frame length: FRAME_BITS*(DIV+1) cycles from E0 until busy falls (busy falls the same cycle frame_done rises).
//   Priority and boundary cases
//     - bps_abort=1 in RUN: next cycle state=IDLE, busy=0, cnt=0, bit_cnt=0. No strobe is issued that cycle.
//       Abort has priority over a coincident HALF/DIV match. Abort in IDLE has no effect.
//     - A start edge while RUN is ignored; the edge detector still tracks the input.
//     - Start edge in the same cycle as frame_done: ignored. bps_start must fall and rise again.
//     - A start edge together with abort in IDLE: abort wins, and the block stays IDLE.
//     - bps_start held high continuously: exactly one frame, no retrigger.
//     - cnt never exceeds DIV. bit_cnt never exceeds FRAME_BITS-1.
//     - bps_hf and bps_full are never high in the same cycle.
// TESTING
//   1. Reset: rst=0 with bps_start toggling -> all outputs 0. After rst=1, the block is IDLE and emits no strobes.
//   2. sel=7, start pulse -> bps_hf at cycle 109 and bps_full at cycle 217 after E0, repeating every 217 cycles.
//      After 10 bits, frame_done at cycle 2170 and busy falls; bit_cnt steps 0..9.
//   3. sel=3, with bps_sel changed to 0 mid-frame -> period stays 2604 cycles; frame_done at cycle 26040.
//   4. sel=7, bps_abort at cycle 500 -> busy=0 next cycle, no further bps_hf/bps_full/frame_done.
//      A new start edge then restarts timing from cnt=0.
//   5. bps_start held high for 3 frames' worth of cycles -> exactly one frame.
//      Start re-pulsed on the frame_done cycle is ignored; a pulse one cycle later starts a new frame.
//   6. sel=7, rst asserted at cycle 300 -> outputs clear immediately.
//      After release, nothing happens until a fresh start edge.

Source files
------------

// File: rtl/uart_bps_gen.sv
// uart_bps_gen: runtime-selectable UART bit-timing generator.
// Emits a mid-bit strobe (RX sampling) and a bit-end strobe (TX shifting)
// for one frame of FRAME_BITS bit periods, then returns to idle on its own.
module uart_bps_gen #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int FRAME_BITS = 10,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bps_start,
    input  logic       bps_abort,
    input  logic [2:0] bps_sel,
    output logic       bps_hf,
    output logic       bps_full,
    output logic [3:0] bit_cnt,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    // Bit-period divisor minus one for each baud select; all constants.
    function automatic logic [CNT_W-1:0] div_for(input logic [2:0] sel);
        case (sel)
            3'd0:    div_for = CNT_W'(CLK_FREQ / 1200   - 1);
            3'd1:    div_for = CNT_W'(CLK_FREQ / 2400   - 1);
            3'd2:    div_for = CNT_W'(CLK_FREQ / 4800   - 1);
            3'd3:    div_for = CNT_W'(CLK_FREQ / 9600   - 1);
            3'd4:    div_for = CNT_W'(CLK_FREQ / 19200  - 1);
            3'd5:    div_for = CNT_W'(CLK_FREQ / 38400  - 1);
            3'd6:    div_for = CNT_W'(CLK_FREQ / 57600  - 1);
            default: div_for = CNT_W'(CLK_FREQ / 115200 - 1);
        endcase
    endfunction

    state_t           r_state;
    logic             r_start_d;
    logic [2:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_cnt;
    logic             r_hf;
    logic             r_full;
    logic             r_done;

    state_t           w_state_nx;
    logic [2:0]       w_sel_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [3:0]       w_bit_nx;
    logic             w_hf_nx;
    logic             w_full_nx;
    logic             w_done_nx;
    logic             w_start_edge;
    logic [CNT_W-1:0] w_div;
    logic [CNT_W-1:0] w_half;

    assign w_start_edge = bps_start & ~r_start_d;
    assign w_div        = div_for(r_sel);
    assign w_half       = w_div >> 1;

    // Track the previous bps_start level for rising-edge detection, in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_start_d <= 1'b0;
        else      r_start_d <= bps_start;
    end

    // Next-state and strobe decode; abort outranks any counter match.
    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit_cnt;
        w_hf_nx    = 1'b0;
        w_full_nx  = 1'b0;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge && !bps_abort) begin
                    w_state_nx = S_RUN;
                    w_sel_nx   = bps_sel;
                    w_cnt_nx   = '0;
                    w_bit_nx   = 4'd0;
                end
            end
            default: begin
                if (bps_abort) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                    w_bit_nx   = 4'd0;
                end else if (r_cnt == w_div) begin
                    w_full_nx = 1'b1;
                    w_cnt_nx  = '0;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_done_nx  = 1'b1;
                        w_bit_nx   = 4'd0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_bit_nx = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    w_hf_nx  = (r_cnt == w_half);
                end
            end
        endcase
    end

    // State, counters and registered strobes; reset ends any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_sel     <= 3'd0;
            r_cnt     <= '0;
            r_bit_cnt <= 4'd0;
            r_hf      <= 1'b0;
            r_full    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sel     <= w_sel_nx;
            r_cnt     <= w_cnt_nx;
            r_bit_cnt <= w_bit_nx;
            r_hf      <= w_hf_nx;
            r_full    <= w_full_nx;
            r_done    <= w_done_nx;
        end
    end

    assign bps_hf     = r_hf;
    assign bps_full   = r_full;
    assign frame_done = r_done;
    assign bit_cnt    = r_bit_cnt;
    assign busy       = (r_state == S_RUN);

endmodule

// File: tb/tb_uart_bps_gen.sv
// Testbench for uart_bps_gen: scenario tasks compared against a frame-timing model.
`timescale 1ns/1ps
module tb_uart_bps_gen;

    localparam int CLK_FREQ = 25_000_000;
    localparam int FB       = 10;
    localparam int CNT_W    = 16;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       bps_start = 1'b0;
    logic       bps_abort = 1'b0;
    logic [2:0] bps_sel   = 3'd7;
    logic       bps_hf;
    logic       bps_full;
    logic [3:0] bit_cnt;
    logic       busy;
    logic       frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_bps_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .FRAME_BITS(FB),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bps_start (bps_start),
        .bps_abort (bps_abort),
        .bps_sel   (bps_sel),
        .bps_hf    (bps_hf),
        .bps_full  (bps_full),
        .bit_cnt   (bit_cnt),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // Divisor from the baud table: CLK_FREQ/baud - 1.
    function automatic int div_of(input int sel);
        int baud;
        case (sel)
            0: baud = 1200;
            1: baud = 2400;
            2: baud = 4800;
            3: baud = 9600;
            4: baud = 19200;
            5: baud = 38400;
            6: baud = 57600;
            default: baud = 115200;
        endcase
        return CLK_FREQ / baud - 1;
    endfunction

    // Expected {hf, full, done, busy, bit_cnt} after the t-th clock edge following E0.
    function automatic logic [7:0] mdl(input int t, input int div);
        int p  = div + 1;
        int hb = div / 2;
        int fl = FB * p;
        logic hf = 1'b0, full = 1'b0, done = 1'b0, bz = 1'b0;
        logic [3:0] bc = 4'd0;
        if (t >= 0 && t < fl) begin
            bz = 1'b1;
            bc = 4'(t / p);
        end
        if (t > 0 && t <= fl && (t % p) == 0) full = 1'b1;
        if (t == fl) done = 1'b1;
        if (t > 0 && t < fl && (t % p) == hb + 1) hf = 1'b1;
        return {hf, full, done, bz, bc};
    endfunction

    function automatic logic [7:0] obs_now();
        return {bps_hf, bps_full, frame_done, busy, bit_cnt};
    endfunction

    task automatic test_reset();
        bps_start = 1'b0; bps_abort = 1'b0; bps_sel = 3'd7; rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_now() !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs_now(), 8'h00);
            end
            bps_start = 1'($urandom_range(1, 0));
        end
        @(negedge clk);
        bps_start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_now() !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, obs_now(), 8'h00);
            end
        end
    endtask

    task automatic test_sel7_frame();
        int div = div_of(7);
        int fl  = FB * (div + 1);
        int first_hf = -1, first_full = -1, done_t = -1;
        logic [7:0] got, exp_v;
        bps_sel = 3'd7;
        @(negedge clk); bps_start = 1'b1;
        @(negedge clk); bps_start = 1'b0;
        for (int t = 0; t <= fl + 20; t++) begin
            if (t != 0) @(negedge clk);
            got = obs_now();
            exp_v = mdl(t, div);
            if (got[7] && first_hf < 0) first_hf = t;
            if (got[6] && first_full < 0) first_full = t;
            if (got[5] && done_t < 0) done_t = t;
            n_chk++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL sel7_frame t=%0d got=%b exp=%b", t, got, exp_v);
            end
        end
        n_chk++;
        if (first_hf !== 109) begin
            n_fail++; $display("FAIL sel7_first_hf got=%0d exp=109", first_hf);
        end
        n_chk++;
        if (first_full !== 217) begin
            n_fail++; $display("FAIL sel7_first_full got=%0d exp=217", first_full);
        end
        n_chk++;
        if (done_t !== 2170) begin
            n_fail++; $display("FAIL sel7_frame_done got=%0d exp=2170", done_t);
        end
    endtask

    task automatic test_sel_change();
        int div = div_of(3);
        int fl  = FB * (div + 1);
        int done_t = -1;
        logic [7:0] got, exp_v;
        bps_sel = 3'd3;
        @(negedge clk); bps_start = 1'b1;
        @(negedge clk); bps_start = 1'b0;
        for (int t = 0; t <= fl + 10; t++) begin
            if (t != 0) @(negedge clk);
            got = obs_now();
            exp_v = mdl(t, div);
            if (got[5] && done_t < 0) done_t = t;
            n_chk++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL sel_change t=%0d got=%b exp=%b", t, got, exp_v);
            end
            if (t == 1000) bps_sel = 3'd0;
        end
        n_chk++;
        if (done_t !== 26040) begin
            n_fail++; $display("FAIL sel3_frame_done got=%0d exp=26040", done_t);
        end
        bps_sel = 3'd7;
    endtask

    task automatic test_abort();
        int div = div_of(7);
        int pts[4] = '{500, 109, 217, 2169};
        logic [7:0] got, exp_v;
        bps_sel = 3'd7;
        for (int k = 0; k < 4; k++) begin
            int ab   = pts[k];
            int stop = ab + 300 + ((k == 0) ? 2000 : 0);
            @(negedge clk); bps_start = 1'b1;
            @(negedge clk); bps_start = 1'b0;
            for (int t = 0; t <= stop; t++) begin
                if (t != 0) @(negedge clk);
                got = obs_now();
                exp_v = (t < ab) ? mdl(t, div) : 8'h00;
                n_chk++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL abort_at_%0d t=%0d got=%b exp=%b", ab, t, got, exp_v);
                end
                bps_abort = (t == ab - 1);
            end
        end
    endtask

    task automatic test_idle_abort();
        int div = div_of(7);
        logic [7:0] got, exp_v;
        bps_sel = 3'd7;
        @(negedge clk); bps_abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_now() !== 8'h00) begin
                n_fail++; $display("FAIL idle_abort cyc=%0d got=%b exp=%b", i, obs_now(), 8'h00);
            end
        end
        bps_start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bps_abort = 1'b0;
            n_chk++;
            if (obs_now() !== 8'h00) begin
                n_fail++; $display("FAIL start_with_abort cyc=%0d got=%b exp=%b", i, obs_now(), 8'h00);
            end
        end
        bps_start = 1'b0;
        @(negedge clk); bps_start = 1'b1;
        @(negedge clk); bps_start = 1'b0;
        for (int t = 0; t <= 302; t++) begin
            if (t != 0) @(negedge clk);
            got = obs_now();
            exp_v = (t < 300) ? mdl(t, div) : 8'h00;
            n_chk++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL start_after_idle_abort t=%0d got=%b exp=%b", t, got, exp_v);
            end
            bps_abort = (t == 299);
        end
    endtask

    task automatic test_held_start();
        int div = div_of(7);
        int fl  = FB * (div + 1);
        logic [7:0] got, exp_v;
        bps_sel = 3'd7;
        @(negedge clk); bps_start = 1'b1;
        @(negedge clk);
        for (int t = 0; t <= 3 * fl; t++) begin
            if (t != 0) @(negedge clk);
            got = obs_now();
            exp_v = mdl(t, div);
            n_chk++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL held_start t=%0d got=%b exp=%b", t, got, exp_v);
            end
        end
        bps_start = 1'b0;
        @(negedge clk); bps_start = 1'b1;
        @(negedge clk); bps_start = 1'b0;
        for (int t = 0; t <= fl + 300; t++) begin
            if (t != 0) @(negedge clk);
            got = obs_now();
            exp_v = mdl(t, div);
            n_chk++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL pulse_on_done t=%0d got=%b exp=%b", t, got, exp_v);
            end
            bps_start = (t == fl - 1);
        end
        @(negedge clk); bps_start = 1'b1;
        @(negedge clk); bps_start = 1'b0;
        for (int t = 0; t <= fl + 300; t++) begin
            if (t != 0) @(negedge clk);
            got = obs_now();
            exp_v = (t <= fl) ? mdl(t, div) : mdl(t - fl - 1, div);
            n_chk++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL pulse_after_done t=%0d got=%b exp=%b", t, got, exp_v);
            end
            bps_start = (t == fl);
        end
        bps_abort = 1'b1;
        @(negedge clk); bps_abort = 1'b0;
        n_chk++;
        if (obs_now() !== 8'h00) begin
            n_fail++; $display("FAIL held_cleanup got=%b exp=%b", obs_now(), 8'h00);
        end
    endtask

    task automatic test_reset_mid();
        int div = div_of(7);
        logic [7:0] got, exp_v;
        bps_sel = 3'd7;
        @(negedge clk); bps_start = 1'b1;
        @(negedge clk); bps_start = 1'b0;
        for (int t = 0; t <= 300; t++) begin
            if (t != 0) @(negedge clk);
            got = obs_now();
            exp_v = mdl(t, div);
            n_chk++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL pre_reset t=%0d got=%b exp=%b", t, got, exp_v);
            end
        end
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if (obs_now() !== 8'h00) begin
            n_fail++; $display("FAIL async_clear got=%b exp=%b", obs_now(), 8'h00);
        end
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_now() !== 8'h00) begin
                n_fail++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=%b", i, obs_now(), 8'h00);
            end
        end
        @(negedge clk); bps_start = 1'b1;
        @(negedge clk); bps_start = 1'b0;
        for (int t = 0; t <= 302; t++) begin
            if (t != 0) @(negedge clk);
            got = obs_now();
            exp_v = (t < 300) ? mdl(t, div) : 8'h00;
            n_chk++;
            if (got !== exp_v) begin
                n_fail++; $display("FAIL restart_after_reset t=%0d got=%b exp=%b", t, got, exp_v);
            end
            bps_abort = (t == 299);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] got, exp_v;
        for (int k = 0; k < 2; k++) begin
            int sel = $urandom_range(7, 5);
            int div = div_of(sel);
            int fl  = FB * (div + 1);
            int gap = $urandom_range(20, 1);
            bps_sel = 3'(sel);
            repeat (gap) @(negedge clk);
            bps_start = 1'b1;
            @(negedge clk);
            for (int t = 0; t <= fl + 50; t++) begin
                if (t != 0) @(negedge clk);
                got = obs_now();
                exp_v = mdl(t, div);
                n_chk++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL random_frame sel=%0d t=%0d got=%b exp=%b", sel, t, got, exp_v);
                end
                bps_sel   = 3'($urandom_range(7, 0));
                bps_start = (t < fl - 5) ? 1'($urandom_range(1, 0)) : 1'b0;
            end
        end
        bps_sel = 3'd7;
    endtask

    initial begin
        test_reset();
        test_sel7_frame();
        test_sel_change();
        test_abort();
        test_idle_abort();
        test_held_start();
        test_reset_mid();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog time limit reached after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
